// File: rtl/butterfly_add_sequencer.sv
// butterfly_add_sequencer
//
// Produces the four add/subtract terms of a radix-2 FFT butterfly with a
// single shared 16-bit sign-magnitude adder, stepped by a small sequencer:
//   X0 = A + B, X1 = A - B (real and imaginary parts).
// B arrives already rotated by the twiddle stage. All words are 16-bit
// sign-magnitude: bit 15 = sign (1 = negative), bits 14:0 = magnitude.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands valid                      (handshake with in_ready)
//   in_ready   operands can be accepted; high only while idle
//   ar, ai     operand A real / imaginary
//   br, bi     operand B real / imaginary
//   out_valid  results valid, held until accepted  (handshake with out_ready)
//   out_ready  downstream accepts results
//   x0r, x0i   X0 = A + B real / imaginary
//   x1r, x1i   X1 = A - B real / imaginary
//   ovf        magnitude carry-out in any of the four operations
//   busy       sequencer is not idle

// Shared sign-magnitude adder. carry is only raised for same-sign adds whose
// magnitude sum leaves bit 14; differing signs subtract and never carry.
module sm_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        carry
);

    logic [14:0] ma;
    logic [14:0] mb;
    logic [15:0] mag_sum;
    logic        same_sign;
    logic        a_larger;

    assign ma        = a[14:0];
    assign mb        = b[14:0];
    assign same_sign = (a[15] == b[15]);
    assign a_larger  = (ma > mb);
    assign mag_sum   = {1'b0, ma} + {1'b0, mb};

    always_comb begin
        sum   = '0;
        carry = 1'b0;
        if (same_sign) begin
            sum   = {a[15], mag_sum[14:0]};
            carry = mag_sum[15];
        end else if (a_larger) begin
            sum = {a[15], ma - mb};
        end else begin
            // Equal magnitudes land here and take the sign of b, so a
            // negative zero (0x8000) is a legitimate result.
            sum = {b[15], mb - ma};
        end
    end

endmodule

module butterfly_add_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ar,
    input  logic [15:0] ai,
    input  logic [15:0] br,
    input  logic [15:0] bi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x0r,
    output logic [15:0] x0i,
    output logic [15:0] x1r,
    output logic [15:0] x1i,
    output logic        ovf,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OP0  = 3'd1,
        OP1  = 3'd2,
        OP2  = 3'd3,
        OP3  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        accept;
    logic        rel;

    // Operands captured at accept; later input changes have no effect.
    logic [15:0] ar_q;
    logic [15:0] ai_q;
    logic [15:0] br_q;
    logic [15:0] bi_q;

    // Shared adder operand mux and result.
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        add_carry;
    logic        op_active;

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and handshake strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rel       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = OP0;
                end
            end
            OP0: state_nxt = OP1;
            OP1: state_nxt = OP2;
            OP2: state_nxt = OP3;
            OP3: state_nxt = DONE;
            DONE: begin
                // in_valid arriving together with out_ready is not looked at
                // here; it is seen in IDLE on the following cycle.
                if (out_ready) begin
                    rel       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign op_active = (state == OP0) || (state == OP1) ||
                       (state == OP2) || (state == OP3);

    // ------------------------------------------------------------------
    // Operand registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q <= '0;
            ai_q <= '0;
            br_q <= '0;
            bi_q <= '0;
        end else if (accept) begin
            ar_q <= ar;
            ai_q <= ai;
            br_q <= br;
            bi_q <= bi;
        end
    end

    // ------------------------------------------------------------------
    // Adder operand mux: X1 terms negate B by flipping its sign bit.
    // ------------------------------------------------------------------
    always_comb begin
        add_a = ar_q;
        add_b = br_q;
        case (state)
            OP0: begin
                add_a = ar_q;
                add_b = br_q;
            end
            OP1: begin
                add_a = ai_q;
                add_b = bi_q;
            end
            OP2: begin
                add_a = ar_q;
                add_b = {~br_q[15], br_q[14:0]};
            end
            OP3: begin
                add_a = ai_q;
                add_b = {~bi_q[15], bi_q[14:0]};
            end
            default: begin
                add_a = ar_q;
                add_b = br_q;
            end
        endcase
    end

    sm_adder u_adder (
        .a     (add_a),
        .b     (add_b),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // ------------------------------------------------------------------
    // Result registers: each term is written at the end of its own step.
    // Accepting a new butterfly clears ovf but leaves old results in
    // place until they are overwritten.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0r <= '0;
            x0i <= '0;
            x1r <= '0;
            x1i <= '0;
        end else begin
            case (state)
                OP0:     x0r <= add_sum;
                OP1:     x0i <= add_sum;
                OP2:     x1r <= add_sum;
                OP3:     x1i <= add_sum;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (op_active && add_carry) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_butterfly_add_sequencer.sv
module tb_butterfly_add_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ar, ai, br, bi;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x0r, x0i, x1r, x1i;
    logic        ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    butterfly_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0r       (x0r),
        .x0i       (x0i),
        .x1r       (x1r),
        .x1i       (x1i),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor: accept cycle numbers and released result bundles.
    int          cyc = 0;
    int          acc_q[$];
    logic [64:0] rel_q[$];
    int          n_rel = 0;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
        if (!rst && out_valid && out_ready) begin
            rel_q.push_back({ovf, x0r, x0i, x1r, x1i});
            n_rel <= n_rel + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference sign-magnitude add: returns {carry, sum}.
    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int ma, mb, s;
        ma = int'(a[14:0]);
        mb = int'(b[14:0]);
        if (a[15] == b[15]) begin
            s = ma + mb;
            return {(s > 32767), a[15], 15'(s % 32768)};
        end else if (ma > mb) begin
            return {1'b0, a[15], 15'(ma - mb)};
        end else begin
            return {1'b0, b[15], 15'(mb - ma)};
        end
    endfunction

    // Reference butterfly: returns {ovf, x0r, x0i, x1r, x1i}.
    function automatic logic [64:0] ref_bfly(input logic [15:0] a_r, input logic [15:0] a_i,
                                             input logic [15:0] b_r, input logic [15:0] b_i);
        logic [16:0] r0, r1, r2, r3;
        r0 = ref_add(a_r, b_r);
        r1 = ref_add(a_i, b_i);
        r2 = ref_add(a_r, b_r ^ 16'h8000);
        r3 = ref_add(a_i, b_i ^ 16'h8000);
        return {r0[16] | r1[16] | r2[16] | r3[16], r0[15:0], r1[15:0], r2[15:0], r3[15:0]};
    endfunction

    function automatic logic [64:0] outs();
        return {ovf, x0r, x0i, x1r, x1i};
    endfunction

    int n_exp_rel = 0;

    // One full butterfly: accept, four op cycles, DONE held for 'stall'
    // cycles, then release. 'noisy' scrambles inputs after the accept;
    // 'same_cycle' raises in_valid together with out_ready in DONE.
    task automatic do_bfly(input logic [15:0] a_r, input logic [15:0] a_i,
                           input logic [15:0] b_r, input logic [15:0] b_i,
                           input int stall, input bit noisy, input bit same_cycle);
        logic [64:0] exp;
        int w;
        exp = ref_bfly(a_r, a_i, b_r, b_i);
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_idle", in_ready, 1);
        ar = a_r; ai = a_i; br = b_r; bi = b_i;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_op0", {busy, in_ready, out_valid}, 3'b100);
        for (int i = 0; i < 3; i++) begin
            if (noisy) begin
                ar = 16'($urandom); ai = 16'($urandom);
                br = 16'($urandom); bi = 16'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            check("no_valid_op", out_valid, 0);
        end
        tick();
        check("valid_done", {out_valid, in_ready, busy}, 3'b101);
        check("result", outs(), exp);
        for (int i = 0; i < stall; i++) begin
            if (noisy) begin
                ar = 16'($urandom); ai = 16'($urandom);
                br = 16'($urandom); bi = 16'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            check("stall_hold", {out_valid, in_ready}, 2'b10);
            check("stall_result", outs(), exp);
        end
        in_valid  = same_cycle;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("released", {out_valid, in_ready, busy}, 3'b010);
        check("result_kept", outs(), exp);
        in_valid = 1'b0;
        n_exp_rel++;
    endtask

    logic [64:0] exp_q[$];

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_ctl", {in_ready, out_valid, busy}, 3'b100);
        check("reset_out", outs(), '0);
        tick();
        rst = 1'b0;

        // Basic add/subtract with mixed signs.
        do_bfly(16'h0005, 16'h0002, 16'h8003, 16'h0001, 0, 0, 0);
        check("basic_direct", outs(), {1'b0, 16'h0002, 16'h0003, 16'h0008, 16'h0001});

        // Magnitude overflow and negative zero.
        do_bfly(16'h0000, 16'h4000, 16'h0000, 16'h4000, 0, 0, 0);
        check("ovf_direct", outs(), {1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h8000});

        // Backpressure with ignored in_valid pulses and input changes.
        do_bfly(16'h7fff, 16'h8001, 16'h0001, 16'hffff, 10, 1, 0);

        // in_valid together with release: only the release happens.
        do_bfly(16'h1234, 16'h8765, 16'h0234, 16'h0765, 2, 0, 1);

        // Throughput: in_valid and out_ready held high for 8 butterflies.
        acc_q.delete(); rel_q.delete(); exp_q.delete();
        begin
            int n, guard;
            n = 0; guard = 0;
            out_ready = 1'b1; in_valid = 1'b1;
            ar = 16'($urandom); ai = 16'($urandom); br = 16'($urandom); bi = 16'($urandom);
            while (n < 8 && guard < 200) begin
                if (in_ready) begin
                    exp_q.push_back(ref_bfly(ar, ai, br, bi));
                    tick();
                    n++;
                    if (n < 8) begin
                        ar = 16'($urandom); ai = 16'($urandom);
                        br = 16'($urandom); bi = 16'($urandom);
                    end else begin
                        in_valid = 1'b0;
                    end
                end else begin
                    tick();
                end
                guard++;
            end
            in_valid = 1'b0;
            guard = 0;
            while (rel_q.size() < 8 && guard < 50) begin
                tick();
                guard++;
            end
            out_ready = 1'b0;
            n_exp_rel += 8;
            check("tput_accepts", acc_q.size(), 8);
            check("tput_releases", rel_q.size(), 8);
            for (int i = 1; i < 8 && i < acc_q.size(); i++)
                check("tput_interval", acc_q[i] - acc_q[i-1], 6);
            for (int i = 0; i < 8 && i < rel_q.size(); i++)
                check("tput_result", rel_q[i], exp_q[i]);
        end

        // Reset during OP2 drops the butterfly.
        ar = 16'h1111; ai = 16'h2222; br = 16'h0333; bi = 16'h0444;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("in_op2_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_ctl", {in_ready, out_valid, busy}, 3'b100);
        check("midrst_out", outs(), '0);
        #1 rst = 1'b0;
        tick();
        tick();
        check("midrst_no_release", n_rel, n_exp_rel);
        do_bfly(16'h8100, 16'h00ff, 16'h8100, 16'h80ff, 1, 0, 0);

        // Random operands with random stalls and input noise.
        for (int i = 0; i < 2000; i++) begin
            do_bfly(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        tick();
        check("release_count", n_rel, n_exp_rel);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
